pipe_wb: RTL and testbench

- Write-back end of the 5-stage MIPS pipeline: the producer side of the register-file/HI/LO write interface that the decode stage reads from.
- Latches MEM-stage results into a MEM/WB pipeline register and selects the final write data at capture.
- Drives registered write ports (rf/hi/lo data, address, enables) straight into the regfile and HI/LO registers.
- Supports stall (hold), flush (bubble insert), and counts retired instructions.

---
 rtl/pipe_wb.sv | 143 ++++++++++++++
 tb/tb_pipe_wb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wb.sv
// MIPS write-back stage: MEM/WB register with write-data selection, stall/flush and retire count.
// Optional PIPE_WB_TRACE_EN adds a registered retirement trace (trace_valid, trace_pc).
module pipe_wb #(
    parameter int unsigned CNT_W   = 32,
    parameter logic [31:0] RST_PC4 = 32'h0040_0004
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rf_waddr,
    input  logic             mem_rf_wena,
    input  logic             mem_hi_wena,
    input  logic             mem_lo_wena,
    input  logic [31:0]      mem_lo_out,
    input  logic [31:0]      mem_pc4,
    input  logic [31:0]      mem_clz_out,
    input  logic [31:0]      mem_dmem_out,
    input  logic [31:0]      mem_alu_out,
    input  logic [31:0]      mem_hi_out,
    input  logic [31:0]      mem_mul_lo,
    input  logic [31:0]      mem_mul_hi,
    input  logic [31:0]      mem_div_r,
    input  logic [31:0]      mem_div_q,
    input  logic [31:0]      mem_rs_data_out,
    input  logic [2:0]       mem_rf_mux_sel,
    input  logic [1:0]       mem_hi_mux_sel,
    input  logic [1:0]       mem_lo_mux_sel,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      hi_wdata,
    output logic [31:0]      lo_wdata,
    output logic [4:0]       rf_waddr,
    output logic             rf_wena,
    output logic             hi_wena,
    output logic             lo_wena,
    output logic             wb_valid,
    output logic [31:0]      wb_pc4,
    output logic [CNT_W-1:0] retire_count
`ifdef PIPE_WB_TRACE_EN
    ,
    output logic             trace_valid,
    output logic [31:0]      trace_pc
`endif
);

    logic [31:0] rf_sel_data;
    logic [31:0] hi_sel_data;
    logic [31:0] lo_sel_data;
    logic        capture;
    logic        retire;

    // Flush has priority over stall; anything else is a capture edge.
    assign capture = !flush && !stall;
    assign retire  = capture && mem_valid;

    always_comb begin
        rf_sel_data = '0;
        unique case (mem_rf_mux_sel)
            3'd0: rf_sel_data = mem_lo_out;
            3'd1: rf_sel_data = mem_pc4;
            3'd2: rf_sel_data = mem_clz_out;
            3'd3: rf_sel_data = '0;
            3'd4: rf_sel_data = mem_dmem_out;
            3'd5: rf_sel_data = mem_alu_out;
            3'd6: rf_sel_data = mem_hi_out;
            3'd7: rf_sel_data = mem_mul_lo;
        endcase
    end

    always_comb begin
        hi_sel_data = '0;
        unique case (mem_hi_mux_sel)
            2'd0: hi_sel_data = mem_div_r;
            2'd1: hi_sel_data = mem_mul_hi;
            2'd2: hi_sel_data = mem_rs_data_out;
            2'd3: hi_sel_data = '0;
        endcase
    end

    always_comb begin
        lo_sel_data = '0;
        unique case (mem_lo_mux_sel)
            2'd0: lo_sel_data = mem_div_q;
            2'd1: lo_sel_data = mem_mul_lo;
            2'd2: lo_sel_data = mem_rs_data_out;
            2'd3: lo_sel_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wdata <= '0;
            hi_wdata <= '0;
            lo_wdata <= '0;
            rf_waddr <= '0;
            rf_wena  <= 1'b0;
            hi_wena  <= 1'b0;
            lo_wena  <= 1'b0;
            wb_valid <= 1'b0;
            wb_pc4   <= RST_PC4;
        end else if (flush) begin
            // Bubble: kill the write-back but keep the data for debug visibility.
            rf_wena  <= 1'b0;
            hi_wena  <= 1'b0;
            lo_wena  <= 1'b0;
            wb_valid <= 1'b0;
        end else if (!stall) begin
            rf_wdata <= rf_sel_data;
            hi_wdata <= hi_sel_data;
            lo_wdata <= lo_sel_data;
            rf_waddr <= mem_rf_waddr;
            rf_wena  <= mem_rf_wena & mem_valid & (mem_rf_waddr != 5'd0);
            hi_wena  <= mem_hi_wena & mem_valid;
            lo_wena  <= mem_lo_wena & mem_valid;
            wb_valid <= mem_valid;
            wb_pc4   <= mem_pc4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

`ifdef PIPE_WB_TRACE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
        end else begin
            trace_valid <= retire;
            if (capture) begin
                trace_pc <= mem_pc4 - 32'd4;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_wb.sv
// Directed self-checking bench for pipe_wb; a second instance with CNT_W=4 covers counter wrap.
module tb_pipe_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, mem_valid;
    logic [4:0]  mem_rf_waddr;
    logic        mem_rf_wena, mem_hi_wena, mem_lo_wena;
    logic [31:0] mem_lo_out, mem_pc4, mem_clz_out, mem_dmem_out, mem_alu_out, mem_hi_out;
    logic [31:0] mem_mul_lo, mem_mul_hi, mem_div_r, mem_div_q, mem_rs_data_out;
    logic [2:0]  mem_rf_mux_sel;
    logic [1:0]  mem_hi_mux_sel, mem_lo_mux_sel;

    logic [31:0] rf_wdata, hi_wdata, lo_wdata, wb_pc4;
    logic [4:0]  rf_waddr;
    logic        rf_wena, hi_wena, lo_wena, wb_valid;
    logic [31:0] retire_count;

    logic [31:0] rf_wdata4, hi_wdata4, lo_wdata4, wb_pc4_4;
    logic [4:0]  rf_waddr4;
    logic        rf_wena4, hi_wena4, lo_wena4, wb_valid4;
    logic [3:0]  retire_count4;

`ifdef PIPE_WB_TRACE_EN
    logic        trace_valid, trace_valid4;
    logic [31:0] trace_pc, trace_pc4;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    pipe_wb u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_rf_waddr(mem_rf_waddr), .mem_rf_wena(mem_rf_wena), .mem_hi_wena(mem_hi_wena),
        .mem_lo_wena(mem_lo_wena), .mem_lo_out(mem_lo_out), .mem_pc4(mem_pc4),
        .mem_clz_out(mem_clz_out), .mem_dmem_out(mem_dmem_out), .mem_alu_out(mem_alu_out),
        .mem_hi_out(mem_hi_out), .mem_mul_lo(mem_mul_lo), .mem_mul_hi(mem_mul_hi),
        .mem_div_r(mem_div_r), .mem_div_q(mem_div_q), .mem_rs_data_out(mem_rs_data_out),
        .mem_rf_mux_sel(mem_rf_mux_sel), .mem_hi_mux_sel(mem_hi_mux_sel),
        .mem_lo_mux_sel(mem_lo_mux_sel), .rf_wdata(rf_wdata), .hi_wdata(hi_wdata),
        .lo_wdata(lo_wdata), .rf_waddr(rf_waddr), .rf_wena(rf_wena), .hi_wena(hi_wena),
        .lo_wena(lo_wena), .wb_valid(wb_valid), .wb_pc4(wb_pc4), .retire_count(retire_count)
`ifdef PIPE_WB_TRACE_EN
        , .trace_valid(trace_valid), .trace_pc(trace_pc)
`endif
    );

    pipe_wb #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_rf_waddr(mem_rf_waddr), .mem_rf_wena(mem_rf_wena), .mem_hi_wena(mem_hi_wena),
        .mem_lo_wena(mem_lo_wena), .mem_lo_out(mem_lo_out), .mem_pc4(mem_pc4),
        .mem_clz_out(mem_clz_out), .mem_dmem_out(mem_dmem_out), .mem_alu_out(mem_alu_out),
        .mem_hi_out(mem_hi_out), .mem_mul_lo(mem_mul_lo), .mem_mul_hi(mem_mul_hi),
        .mem_div_r(mem_div_r), .mem_div_q(mem_div_q), .mem_rs_data_out(mem_rs_data_out),
        .mem_rf_mux_sel(mem_rf_mux_sel), .mem_hi_mux_sel(mem_hi_mux_sel),
        .mem_lo_mux_sel(mem_lo_mux_sel), .rf_wdata(rf_wdata4), .hi_wdata(hi_wdata4),
        .lo_wdata(lo_wdata4), .rf_waddr(rf_waddr4), .rf_wena(rf_wena4), .hi_wena(hi_wena4),
        .lo_wena(lo_wena4), .wb_valid(wb_valid4), .wb_pc4(wb_pc4_4),
        .retire_count(retire_count4)
`ifdef PIPE_WB_TRACE_EN
        , .trace_valid(trace_valid4), .trace_pc(trace_pc4)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Distinct constant per data source so a wrong select shows up as a wrong value.
    task automatic set_sources();
        mem_lo_out      = 32'h0000_00A0;
        mem_clz_out     = 32'h0000_00C2;
        mem_dmem_out    = 32'hDEAD_BEEF;
        mem_alu_out     = 32'h1234_5678;
        mem_hi_out      = 32'h0000_00A6;
        mem_mul_lo      = 32'hFFFF_FFFE;
        mem_mul_hi      = 32'h0000_0001;
        mem_div_r       = 32'h0000_00D0;
        mem_div_q       = 32'h0000_00D1;
        mem_rs_data_out = 32'h0000_00E2;
    endtask

    task automatic set_instr(input logic v, input logic [2:0] rs, input logic [1:0] hs,
                             input logic [1:0] ls, input logic [4:0] wa, input logic rw,
                             input logic hw, input logic lw, input logic [31:0] pc4);
        mem_valid      = v;
        mem_rf_mux_sel = rs;
        mem_hi_mux_sel = hs;
        mem_lo_mux_sel = ls;
        mem_rf_waddr   = wa;
        mem_rf_wena    = rw;
        mem_hi_wena    = hw;
        mem_lo_wena    = lw;
        mem_pc4        = pc4;
    endtask

    initial begin
        // Reset held with random inputs
        rst = 1'b0;
        stall = 1'($urandom); flush = 1'($urandom);
        mem_valid = 1'b1; mem_rf_wena = 1'b1; mem_hi_wena = 1'b1; mem_lo_wena = 1'b1;
        mem_rf_waddr = 5'($urandom); mem_rf_mux_sel = 3'($urandom);
        mem_hi_mux_sel = 2'($urandom); mem_lo_mux_sel = 2'($urandom);
        mem_lo_out = $urandom; mem_pc4 = $urandom; mem_clz_out = $urandom;
        mem_dmem_out = $urandom; mem_alu_out = $urandom; mem_hi_out = $urandom;
        mem_mul_lo = $urandom; mem_mul_hi = $urandom; mem_div_r = $urandom;
        mem_div_q = $urandom; mem_rs_data_out = $urandom;
        repeat (3) step();
        check_eq("rst_rf_wena", rf_wena, 0);
        check_eq("rst_hi_wena", hi_wena, 0);
        check_eq("rst_lo_wena", lo_wena, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_rf_wdata", rf_wdata, 0);
        check_eq("rst_rf_waddr", rf_waddr, 0);
        check_eq("rst_count", retire_count, 0);
        check_eq("rst_pc4", wb_pc4, 32'h0040_0004);
`ifdef PIPE_WB_TRACE_EN
        check_eq("rst_trace_valid", trace_valid, 0);
        check_eq("rst_trace_pc", trace_pc, 0);
`endif

        stall = 1'b0; flush = 1'b0;
        set_sources();
        set_instr(1'b0, 3'd0, 2'd3, 2'd3, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0040_0004);
        rst = 1'b1;
        step();
        check_eq("bubble_count", retire_count, 0);

        // ALU write
        set_instr(1'b1, 3'd5, 2'd3, 2'd3, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0040_0008);
        step();
        check_eq("alu_wdata", rf_wdata, 32'h1234_5678);
        check_eq("alu_waddr", rf_waddr, 8);
        check_eq("alu_wena", rf_wena, 1);
        check_eq("alu_hi_wena", hi_wena, 0);
        check_eq("alu_valid", wb_valid, 1);
        check_eq("alu_pc4", wb_pc4, 32'h0040_0008);
        check_eq("alu_count", retire_count, 1);
`ifdef PIPE_WB_TRACE_EN
        check_eq("alu_trace_valid", trace_valid, 1);
        check_eq("alu_trace_pc", trace_pc, 32'h0040_0004);
`endif

        // r0 protection
        set_instr(1'b1, 3'd5, 2'd3, 2'd3, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0040_000C);
        step();
        check_eq("r0_wena", rf_wena, 0);
        check_eq("r0_count", retire_count, 2);

        // Load
        set_instr(1'b1, 3'd4, 2'd3, 2'd3, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0040_0010);
        step();
        check_eq("ld_wdata", rf_wdata, 32'hDEAD_BEEF);
        check_eq("ld_waddr", rf_waddr, 3);
        check_eq("ld_wena", rf_wena, 1);

        // mult: HI and LO in the same edge
        set_instr(1'b1, 3'd5, 2'd1, 2'd1, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0040_0014);
        step();
        check_eq("mul_hi", hi_wdata, 32'h1);
        check_eq("mul_lo", lo_wdata, 32'hFFFF_FFFE);
        check_eq("mul_hi_wena", hi_wena, 1);
        check_eq("mul_lo_wena", lo_wena, 1);
        check_eq("mul_rf_wena", rf_wena, 0);
        check_eq("mul_count", retire_count, 4);

        // Remaining select encodings
        set_instr(1'b1, 3'd3, 2'd0, 2'd2, 5'd4, 1'b1, 1'b1, 1'b1, 32'h0040_0018);
        step();
        check_eq("sel3_rf", rf_wdata, 0);
        check_eq("sel0_hi", hi_wdata, 32'hD0);
        check_eq("sel2_lo", lo_wdata, 32'hE2);
        set_instr(1'b1, 3'd7, 2'd3, 2'd0, 5'd4, 1'b1, 1'b1, 1'b1, 32'h0040_001C);
        step();
        check_eq("sel7_rf", rf_wdata, 32'hFFFF_FFFE);
        check_eq("sel3_hi", hi_wdata, 0);
        check_eq("sel0_lo", lo_wdata, 32'hD1);
        set_instr(1'b1, 3'd0, 2'd2, 2'd3, 5'd4, 1'b1, 1'b1, 1'b1, 32'h0040_0020);
        step();
        check_eq("sel0_rf", rf_wdata, 32'hA0);
        check_eq("sel2_hi", hi_wdata, 32'hE2);
        check_eq("sel3_lo", lo_wdata, 0);
        set_instr(1'b1, 3'd2, 2'd1, 2'd1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0040_0024);
        step();
        check_eq("sel2_rf", rf_wdata, 32'hC2);
        set_instr(1'b1, 3'd6, 2'd1, 2'd1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0040_0028);
        step();
        check_eq("sel6_rf", rf_wdata, 32'hA6);
        check_eq("sel_count", retire_count, 9);

        // Instruction A, then a 3-cycle stall with changing inputs
        set_instr(1'b1, 3'd1, 2'd3, 2'd3, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0000_0500);
        step();
        check_eq("a_wdata", rf_wdata, 32'h500);
        check_eq("a_count", retire_count, 10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 3'd5, 2'd1, 2'd1, 5'(10 + i), 1'b1, 1'b1, 1'b1, 32'h900 + i);
            step();
            check_eq("stall_wdata", rf_wdata, 32'h500);
            check_eq("stall_waddr", rf_waddr, 9);
            check_eq("stall_wena", rf_wena, 1);
            check_eq("stall_valid", wb_valid, 1);
            check_eq("stall_count", retire_count, 10);
`ifdef PIPE_WB_TRACE_EN
            check_eq("stall_trace_valid", trace_valid, 0);
`endif
        end

        // Flush together with stall
        flush = 1'b1;
        step();
        check_eq("flush_valid", wb_valid, 0);
        check_eq("flush_rf_wena", rf_wena, 0);
        check_eq("flush_hi_wena", hi_wena, 0);
        check_eq("flush_lo_wena", lo_wena, 0);
        check_eq("flush_wdata", rf_wdata, 32'h500);
        check_eq("flush_pc4", wb_pc4, 32'h500);
        check_eq("flush_count", retire_count, 10);

        // Bubble capture: enables masked by mem_valid
        flush = 1'b0; stall = 1'b0;
        set_instr(1'b0, 3'd5, 2'd1, 2'd1, 5'd5, 1'b1, 1'b1, 1'b1, 32'h0000_0600);
        step();
        check_eq("bub_rf_wena", rf_wena, 0);
        check_eq("bub_hi_wena", hi_wena, 0);
        check_eq("bub_valid", wb_valid, 0);
        check_eq("bub_wdata", rf_wdata, 32'h1234_5678);
        check_eq("bub_count", retire_count, 10);
        check_eq("bub_count4", retire_count4, 10);

        // Asynchronous reset in the middle of a stall
        stall = 1'b1;
        set_instr(1'b1, 3'd5, 2'd3, 2'd3, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0700);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_count", retire_count, 0);
        check_eq("arst_pc4", wb_pc4, 32'h0040_0004);
        check_eq("arst_count4", retire_count4, 0);
        rst = 1'b1;
        step();
        check_eq("arst_stall_valid", wb_valid, 0);
        check_eq("arst_stall_count", retire_count, 0);

        // Wrap of the 4-bit counter after 16 retirements
        stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
`ifdef PIPE_WB_TRACE_EN
            if (trace_valid4) n_pulses++;
`endif
            if (i == 14) check_eq("wrap_15", retire_count4, 15);
        end
        check_eq("wrap_count4", retire_count4, 0);
        check_eq("wrap_count32", retire_count, 16);
`ifdef PIPE_WB_TRACE_EN
        check_eq("wrap_pulses", n_pulses, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
